// File: rtl/lcd_frame_writer.sv
// HD44780 character-frame engine: a ROWS x COLS text buffer written by the host, streamed
// row by row (dirty rows only) to the hd44780 driver over its cmd/vchr/busy handshake.
module lcd_frame_writer #(
  parameter int ROWS           = 4,
  parameter int COLS           = 20,
  parameter int POWERUP_CYCLES = 100_000_000,
  parameter int TIMEOUT_CYCLES = 1_000_000
) (
  input  logic                                     clk,
  input  logic                                     reset,
  input  logic                                     wr_en,
  input  logic [((ROWS > 1) ? $clog2(ROWS) : 1)-1:0] wr_row,
  input  logic [((COLS > 1) ? $clog2(COLS) : 1)-1:0] wr_col,
  input  logic [7:0]                               wr_char,
  output logic                                     ready,
  output logic                                     idle,
  output logic                                     err,
  output logic [1:0]                               lcd_cmd,
  output logic [8:0]                               lcd_vchr,
  input  logic                                     lcd_busy
);
  localparam int RW    = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int CW    = (COLS > 1) ? $clog2(COLS) : 1;
  localparam int DEPTH = ROWS * COLS;
  localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int PW    = $clog2(POWERUP_CYCLES + 1);
  localparam int TW    = $clog2(TIMEOUT_CYCLES + 1);

  localparam logic [1:0] CMD_IDLE  = 2'd0;
  localparam logic [1:0] CMD_INIT  = 2'd1;
  localparam logic [1:0] CMD_WRITE = 2'd2;

  typedef enum logic [2:0] {S_CLEAR, S_POWERUP, S_SCAN, S_READ, S_LOAD, S_REQ, S_WAIT} state_t;
  typedef enum logic [1:0] {PH_INIT, PH_ADDR, PH_CHAR} phase_t;

  state_t          state_q;
  phase_t          phase_q;
  logic [RW-1:0]   row_q, last_q, pick_row;
  logic [CW-1:0]   col_q;
  logic [AW-1:0]   clr_q, wa, ra;
  logic [PW-1:0]   pwr_q;
  logic [TW-1:0]   tmo_q;
  logic [ROWS-1:0] dirty_q, dirty_d;
  logic            pick_vld, host_ok, we, pwr_done, tmo_done;
  logic [7:0]      wd, rd_data_q;
  logic [7:0]      mem [DEPTH];

  function automatic logic [6:0] row_base(input logic [RW-1:0] r);
    logic [1:0] r2;
    r2 = 2'(r);
    row_base = (r2[0] ? 7'h40 : 7'h00) + (r2[1] ? 7'(COLS) : 7'h00);
  endfunction

  assign host_ok  = wr_en & ready & (32'(wr_row) < ROWS) & (32'(wr_col) < COLS);
  assign pwr_done = (pwr_q >= PW'(POWERUP_CYCLES - 1));
  assign tmo_done = (tmo_q == TW'(TIMEOUT_CYCLES - 1));
  assign ra       = AW'(32'(row_q) * COLS + 32'(col_q));
  assign idle     = ready & ~|dirty_q & (state_q == S_SCAN) & (lcd_cmd == CMD_IDLE);

  always_comb begin
    we = 1'b0;
    wa = '0;
    wd = wr_char;
    if (state_q == S_CLEAR) begin
      we = 1'b1;
      wa = clr_q;
      wd = 8'h20;
    end else if (host_ok) begin
      we = 1'b1;
      wa = AW'(32'(wr_row) * COLS + 32'(wr_col));
    end
  end

  // Single-port write, single-port registered read: same-address collisions read the old byte.
  always_ff @(posedge clk) begin
    if (we) mem[wa] <= wd;
    rd_data_q <= mem[ra];
  end

  // Round-robin: the nearest dirty row after the last one picked wins.
  always_comb begin
    pick_vld = 1'b0;
    pick_row = '0;
    for (int k = ROWS; k >= 1; k--) begin
      if (dirty_q[(int'(last_q) + k) % ROWS]) begin
        pick_vld = 1'b1;
        pick_row = RW'((int'(last_q) + k) % ROWS);
      end
    end
  end

  // Host set is applied last so it beats the scan clear and covers a row mid-transfer.
  always_comb begin
    dirty_d = dirty_q;
    if (state_q == S_SCAN && pick_vld) dirty_d[pick_row] = 1'b0;
    if (state_q == S_REQ && !lcd_busy && tmo_done && phase_q != PH_INIT) dirty_d[row_q] = 1'b1;
    if (host_ok) dirty_d[wr_row] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_CLEAR;
      phase_q  <= PH_INIT;
      row_q    <= '0;
      col_q    <= '0;
      clr_q    <= '0;
      pwr_q    <= '0;
      tmo_q    <= '0;
      last_q   <= RW'(ROWS - 1);
      dirty_q  <= '1;
      ready    <= 1'b0;
      err      <= 1'b0;
      lcd_cmd  <= CMD_IDLE;
      lcd_vchr <= '0;
    end else begin
      dirty_q <= dirty_d;
      if (!pwr_done) pwr_q <= pwr_q + 1'b1;
      case (state_q)
        S_CLEAR: begin
          clr_q <= clr_q + 1'b1;
          if (clr_q == AW'(DEPTH - 1)) state_q <= S_POWERUP;
        end
        S_POWERUP: begin
          if (pwr_done) begin
            lcd_cmd <= CMD_INIT;
            phase_q <= PH_INIT;
            tmo_q   <= '0;
            state_q <= S_REQ;
          end
        end
        S_SCAN: begin
          if (pick_vld) begin
            row_q    <= pick_row;
            last_q   <= pick_row;
            col_q    <= '0;
            lcd_vchr <= {2'b11, row_base(pick_row)};
            lcd_cmd  <= CMD_WRITE;
            phase_q  <= PH_ADDR;
            tmo_q    <= '0;
            state_q  <= S_REQ;
          end
        end
        S_READ: state_q <= S_LOAD;
        S_LOAD: begin
          lcd_vchr <= {1'b0, rd_data_q};
          lcd_cmd  <= CMD_WRITE;
          phase_q  <= PH_CHAR;
          tmo_q    <= '0;
          state_q  <= S_REQ;
        end
        S_REQ: begin
          if (lcd_busy) begin
            lcd_cmd <= CMD_IDLE;
            state_q <= S_WAIT;
          end else if (tmo_done) begin
            err     <= 1'b1;
            lcd_cmd <= CMD_IDLE;
            if (phase_q == PH_INIT) begin
              pwr_q   <= '0;
              state_q <= S_POWERUP;
            end else begin
              state_q <= S_SCAN;
            end
          end else begin
            tmo_q <= tmo_q + 1'b1;
          end
        end
        S_WAIT: begin
          if (!lcd_busy) begin
            if (phase_q == PH_INIT) begin
              ready   <= 1'b1;
              state_q <= S_SCAN;
            end else if (phase_q == PH_ADDR) begin
              state_q <= S_READ;
            end else if (col_q == CW'(COLS - 1)) begin
              state_q <= S_SCAN;
            end else begin
              col_q   <= col_q + 1'b1;
              state_q <= S_READ;
            end
          end
        end
        default: state_q <= S_CLEAR;
      endcase
    end
  end
endmodule

// File: tb/tb_lcd_frame_writer.sv
// Bench for lcd_frame_writer: models the hd44780 driver handshake, keeps a text-buffer reference
// model and a queue of expected driver transfers that a monitor process checks.
module tb_lcd_frame_writer;
  localparam int ROWS = 4, COLS = 20, PWR = 200, TMO = 50;
  localparam logic [6:0] ROW_ADDR [4] = '{7'h00, 7'h40, 7'h14, 7'h54};

  logic       clk = 1'b0, reset = 1'b1, wr_en = 1'b0, lcd_busy = 1'b0;
  logic [1:0] wr_row = '0;
  logic [4:0] wr_col = '0;
  logic [7:0] wr_char = '0;
  logic       ready, idle, err;
  logic [1:0] lcd_cmd;
  logic [8:0] lcd_vchr;

  int checks = 0, errors = 0, n_pop = 0, req_cnt = 0, drop_at = -1;
  logic [10:0] exp_q [$];
  logic [7:0]  mdl [ROWS][COLS];

  lcd_frame_writer #(.ROWS(ROWS), .COLS(COLS), .POWERUP_CYCLES(PWR), .TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .reset(reset), .wr_en(wr_en), .wr_row(wr_row), .wr_col(wr_col), .wr_char(wr_char),
    .ready(ready), .idle(idle), .err(err), .lcd_cmd(lcd_cmd), .lcd_vchr(lcd_vchr), .lcd_busy(lcd_busy)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0h, want %0h", name, act, expv);
    end
  endtask

  task automatic clear_model();
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++) mdl[r][c] = 8'h20;
  endtask

  // First n transfers of a row burst: the DDRAM address command, then the characters.
  task automatic push_row(input int r, input int n);
    exp_q.push_back({2'd2, 2'b11, ROW_ADDR[r]});
    for (int c = 0; c < n - 1; c++) exp_q.push_back({2'd2, 1'b0, mdl[r][c]});
  endtask

  task automatic push_boot();
    exp_q.push_back({2'd1, 9'h000});
    for (int r = 0; r < ROWS; r++) push_row(r, COLS + 1);
  endtask

  task automatic wr(input int r, input int c, input logic [7:0] ch, input bit acc);
    wr_en = 1'b1;
    wr_row = 2'(r);
    wr_col = 5'(c);
    wr_char = ch;
    if (acc) mdl[r][c] = ch;
    tick();
    wr_en = 1'b0;
  endtask

  task automatic prewrites();
    for (int i = 0; i < 4; i++)
      wr($urandom_range(0, 3), $urandom_range(0, 19), 8'($urandom_range(33, 126)), 1'b0);
    wr(3, 20, 8'h5A, 1'b0);
    wr(0, 31, 8'h5B, 1'b0);
  endtask

  task automatic wait_idle(input int bound, input string name);
    int n = 0;
    while (!(idle === 1'b1 && exp_q.size() == 0) && n < bound) begin
      tick();
      n++;
    end
    checks++;
    if (n >= bound) begin
      errors++;
      $display("FAIL %s: idle not reached in %0d cycles, %0d transfers pending", name, bound, exp_q.size());
    end
  endtask

  task automatic wait_pop(input int target, input int bound, input string name);
    int n = 0;
    while (n_pop < target && n < bound) begin
      tick();
      n++;
    end
    checks++;
    if (n >= bound) begin
      errors++;
      $display("FAIL %s: got %0d transfers, want %0d", name, n_pop, target);
    end
  endtask

  // Driver model: busy rises 3 cycles after a request and stays high 10 cycles.
  initial begin
    int dst, dcnt;
    dst = 0;
    dcnt = 0;
    forever begin
      @(posedge clk);
      #1;
      if (reset) begin
        lcd_busy = 1'b0;
        dst = 0;
      end else begin
        case (dst)
          0: if (lcd_cmd != 2'd0) begin
               if (req_cnt == drop_at) dst = 3;
               else begin dcnt = 3; dst = 1; end
               req_cnt++;
             end
          1: begin
               dcnt--;
               if (dcnt == 0) begin lcd_busy = 1'b1; dcnt = 10; dst = 2; end
             end
          2: begin
               dcnt--;
               if (dcnt == 0) begin lcd_busy = 1'b0; dst = 0; end
             end
          default: if (lcd_cmd == 2'd0) dst = 0;
        endcase
      end
    end
  end

  // Monitor: an accepted transfer is a cycle with a request pending and busy high.
  initial begin
    logic [1:0]  pc;
    logic [8:0]  pv;
    logic [10:0] e;
    pc = '0;
    pv = '0;
    forever begin
      @(negedge clk);
      if (!reset && pc != 2'd0) begin
        checks++;
        if (lcd_vchr !== pv) begin
          errors++;
          $display("FAIL vchr_hold: got %03h, want %03h", lcd_vchr, pv);
        end
      end
      if (!reset && lcd_cmd != 2'd0 && lcd_busy) begin
        n_pop++;
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL xfer%0d: got cmd=%0d vchr=%03h, want no transfer", n_pop, lcd_cmd, lcd_vchr);
        end else begin
          e = exp_q.pop_front();
          if (lcd_cmd !== e[10:9] || (e[10:9] == 2'd2 && lcd_vchr !== e[8:0])) begin
            errors++;
            $display("FAIL xfer%0d: got cmd=%0d vchr=%03h, want cmd=%0d vchr=%03h",
                     n_pop, lcd_cmd, lcd_vchr, e[10:9], e[8:0]);
          end
        end
      end
      pc = lcd_cmd;
      pv = lcd_vchr;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete, %0d checks %0d errors", checks, errors);
    $fatal(1, "watchdog");
  end

  initial begin
    int base, r, c;
    logic [7:0] ch;
    clear_model();
    repeat (3) tick();
    @(negedge clk);
    chk("rst_ready", 32'(ready), 32'd0);
    chk("rst_idle", 32'(idle), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_cmd", 32'(lcd_cmd), 32'd0);
    chk("rst_vchr", 32'(lcd_vchr), 32'd0);
    tick();
    reset = 1'b0;

    // Boot: clear, power-up wait, INIT, then every row of spaces.
    push_boot();
    repeat (100) tick();
    chk("pre_ready", 32'(ready), 32'd0);
    prewrites();
    wait_idle(5000, "boot_idle");
    chk("boot_ready", 32'(ready), 32'd1);
    chk("boot_err", 32'(err), 32'd0);

    wr(2, 5, 8'h41, 1'b1);
    push_row(2, COLS + 1);
    wait_idle(1000, "single_idle");

    wr(2, 20, 8'h58, 1'b0);
    wr(1, 31, 8'h59, 1'b0);
    repeat (40) tick();
    chk("oor_idle", 32'(idle), 32'd1);

    for (int i = 0; i < 3; i++) begin
      r = $urandom_range(0, 3);
      c = $urandom_range(0, 19);
      ch = 8'($urandom_range(33, 126));
      wr(r, c, ch, 1'b1);
      push_row(r, COLS + 1);
      wait_idle(1000, "rand_idle");
    end

    // Write into row 1 while it is being sent, then rows 0 and 3 during the resend.
    base = n_pop;
    wr(1, 5, 8'($urandom_range(33, 126)), 1'b1);
    push_row(1, COLS + 1);
    wait_pop(base + 3, 200, "mid_burst");
    wr(1, 0, 8'h42, 1'b1);
    push_row(1, COLS + 1);
    wait_pop(base + COLS + 2, 800, "resend_start");
    wr(0, $urandom_range(0, 19), 8'($urandom_range(33, 126)), 1'b1);
    wr(3, $urandom_range(0, 19), 8'($urandom_range(33, 126)), 1'b1);
    push_row(3, COLS + 1);
    push_row(0, COLS + 1);
    wait_idle(2000, "rr_idle");

    // Third character of the next burst is never acknowledged.
    chk("pre_tmo_err", 32'(err), 32'd0);
    drop_at = req_cnt + 3;
    wr(2, 7, 8'($urandom_range(33, 126)), 1'b1);
    push_row(2, 3);
    push_row(2, COLS + 1);
    wait_idle(2000, "tmo_idle");
    chk("tmo_err", 32'(err), 32'd1);
    drop_at = -1;

    // Reset in the middle of a character transfer.
    base = n_pop;
    wr(0, 3, 8'($urandom_range(33, 126)), 1'b1);
    push_row(0, COLS + 1);
    wait_pop(base + 4, 200, "pre_reset");
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("mid_rst_cmd", 32'(lcd_cmd), 32'd0);
    chk("mid_rst_ready", 32'(ready), 32'd0);
    chk("mid_rst_err", 32'(err), 32'd0);
    chk("mid_rst_idle", 32'(idle), 32'd0);
    exp_q.delete();
    tick();
    reset = 1'b0;
    clear_model();
    push_boot();
    repeat (100) tick();
    chk("pre_ready2", 32'(ready), 32'd0);
    prewrites();
    wait_idle(5000, "reboot_idle");
    chk("reboot_ready", 32'(ready), 32'd1);
    chk("reboot_err", 32'(err), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
